cr_cceip_ib_arb: RTL and testbench

//  Round-robin, job-granular arbiter that shares the single cr_cceip_64 inbound AXI-S port between N_REQ hosts.
//  A job is every beat from the first beat after grant through the beat carrying tlast (CQE/EoT tail).
//  The grant is locked for a whole job, so header, data and tail frames of one job are never interleaved with another host's.

---
 rtl/cr_cceip_ib_arb_if.sv | 31 +++
 rtl/cr_cceip_ib_arb.sv | 78 +++++++
 tb/tb_cr_cceip_ib_arb.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_cceip_ib_arb_if.sv
// cr_cceip_ib_arb_if: per-host AXI-S inbound slaves plus the shared engine ib_* port of cr_cceip_ib_arb.
interface cr_cceip_ib_arb_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 64,
  parameter int SW    = 8,
  parameter int UW    = 8,
  parameter int IW    = 1
);
  logic [N_REQ-1:0]    s_tvalid;
  logic [N_REQ-1:0]    s_tready;
  logic [N_REQ-1:0]    s_tlast;
  logic [N_REQ*DW-1:0] s_tdata;
  logic [N_REQ*SW-1:0] s_tstrb;
  logic [N_REQ*UW-1:0] s_tuser;
  logic [N_REQ*IW-1:0] s_tid;
  logic                ib_tvalid;
  logic                ib_tready;
  logic                ib_tlast;
  logic [DW-1:0]       ib_tdata;
  logic [SW-1:0]       ib_tstrb;
  logic [UW-1:0]       ib_tuser;
  logic [IW-1:0]       ib_tid;
  modport slave (
    input  s_tvalid, s_tlast, s_tdata, s_tstrb, s_tuser, s_tid, ib_tready,
    output s_tready, ib_tvalid, ib_tlast, ib_tdata, ib_tstrb, ib_tuser, ib_tid
  );
  modport master (
    output s_tvalid, s_tlast, s_tdata, s_tstrb, s_tuser, s_tid, ib_tready,
    input  s_tready, ib_tvalid, ib_tlast, ib_tdata, ib_tstrb, ib_tuser, ib_tid
  );
endinterface

// File: rtl/cr_cceip_ib_arb.sv
// cr_cceip_ib_arb: round-robin job-granular arbiter sharing the cr_cceip_64 inbound AXI-S port.
// Define CR_CCEIP_IB_ARB_STATS_EN to add saturating per-host job counters on job_cnt.
module cr_cceip_ib_arb #(
  parameter int N_REQ = 4,
  parameter int DW    = 64,
  parameter int SW    = 8,
  parameter int UW    = 8,
  parameter int IW    = 1,
  localparam int GW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  cr_cceip_ib_arb_if.slave     bus,
  output logic                 grant_vld,
  output logic [GW-1:0]        grant_idx
`ifdef CR_CCEIP_IB_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]  job_cnt
`endif
);
  typedef enum logic {IDLE, XFER} state_e;
  state_e        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d, grant_idx_q, grant_idx_d, pick;
  logic          grant_vld_q, grant_vld_d, pick_vld, xfer, job_end;
  function automatic logic [GW-1:0] wrap(input logic [GW-1:0] p, input int k);
    return GW'((int'(p) + k) % N_REQ);
  endfunction
  assign xfer          = state_q == XFER && !rst;
  assign bus.s_tready  = xfer ? N_REQ'(bus.ib_tready) << grant_idx_q : '0;
  assign bus.ib_tvalid = xfer & bus.s_tvalid[grant_idx_q];
  assign bus.ib_tlast  = xfer & bus.s_tlast[grant_idx_q];
  assign bus.ib_tdata  = xfer ? bus.s_tdata[grant_idx_q*DW +: DW] : '0;
  assign bus.ib_tstrb  = xfer ? bus.s_tstrb[grant_idx_q*SW +: SW] : '0;
  assign bus.ib_tuser  = xfer ? bus.s_tuser[grant_idx_q*UW +: UW] : '0;
  assign bus.ib_tid    = xfer ? bus.s_tid[grant_idx_q*IW +: IW] : '0;
  assign job_end       = bus.ib_tvalid & bus.ib_tready & bus.ib_tlast;
  assign grant_vld     = grant_vld_q;
  assign grant_idx     = grant_idx_q;
  // descending scan so the host closest to rr_ptr is the last, winning assignment
  always_comb begin
    pick     = rr_ptr_q;
    pick_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.s_tvalid[wrap(rr_ptr_q, k)]) begin
        pick     = wrap(rr_ptr_q, k);
        pick_vld = 1'b1;
      end
    end
    state_d     = state_q == IDLE ? (pick_vld ? XFER : IDLE) : (job_end ? IDLE : XFER);
    grant_idx_d = state_q == IDLE && pick_vld ? pick : grant_idx_q;
    rr_ptr_d    = job_end ? wrap(grant_idx_q, 1) : rr_ptr_q;
    grant_vld_d = state_d == XFER;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      grant_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      grant_vld_q <= grant_vld_d;
    end
  end
`ifdef CR_CCEIP_IB_ARB_STATS_EN
  logic [N_REQ*16-1:0] job_cnt_q, job_cnt_d;
  always_comb begin
    job_cnt_d = job_cnt_q;
    for (int i = 0; i < N_REQ; i++)
      if (job_end && grant_idx_q == GW'(i) && job_cnt_q[i*16 +: 16] != 16'hffff)
        job_cnt_d[i*16 +: 16] = job_cnt_q[i*16 +: 16] + 16'd1;
  end
  always_ff @(posedge clk) job_cnt_q <= rst ? '0 : job_cnt_d;
  assign job_cnt = job_cnt_q;
`endif
endmodule

// File: tb/tb_cr_cceip_ib_arb.sv
// tb_cr_cceip_ib_arb: directed bench with a job-level reference model checked every cycle.
module tb_cr_cceip_ib_arb;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       grant_vld;
  logic [1:0] grant_idx;
`ifdef CR_CCEIP_IB_ARB_STATS_EN
  logic [N*16-1:0] job_cnt;
`endif
  cr_cceip_ib_arb_if #(.N_REQ(N)) bus ();
  cr_cceip_ib_arb #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_vld(grant_vld), .grant_idx(grant_idx)
`ifdef CR_CCEIP_IB_ARB_STATS_EN
    , .job_cnt(job_cnt)
`endif
  );
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", n, a, e, cyc);
    end
  endtask
  function automatic logic [63:0] beat_data(input int h, input int j, input int b);
    return {8'(h), 24'(j), 32'(b)};
  endfunction

  typedef struct {int idx; logic [63:0] d; logic [7:0] s; logic [7:0] u; logic l;} beat_t;
  beat_t log_q[$];
  int    grant_log[$], grant_cyc[$];
  int    len[N], jobs[N], beat[N], jid[N];
  bit    hold[N], acc[N];
  bit    prev_gv = 1'b0;

  // host sources: each host walks its job list, advancing on accepted beats
  always @(negedge clk) begin
    for (int h = 0; h < N; h++) acc[h] = !rst && bus.s_tvalid[h] && bus.s_tready[h];
    if (!rst && bus.ib_tvalid && bus.ib_tready)
      log_q.push_back('{int'(grant_idx), bus.ib_tdata, bus.ib_tstrb, bus.ib_tuser, bus.ib_tlast});
    if (grant_vld && !prev_gv) begin
      grant_log.push_back(int'(grant_idx));
      grant_cyc.push_back(cyc);
    end
    prev_gv = grant_vld;
  end
  always @(posedge clk) begin
    cyc++;
    for (int h = 0; h < N; h++) begin
      if (rst) beat[h] = 0;
      else if (acc[h]) begin
        if (beat[h] == len[h] - 1) begin
          beat[h] = 0;
          jobs[h]--;
          jid[h]++;
        end else beat[h]++;
      end
    end
    #1;
    for (int h = 0; h < N; h++) begin
      bus.s_tvalid[h]          = jobs[h] > 0 && !hold[h];
      bus.s_tlast[h]           = beat[h] == len[h] - 1;
      bus.s_tdata[h*64 +: 64]  = beat_data(h, jid[h], beat[h]);
      bus.s_tstrb[h*8 +: 8]    = beat[h] == 7 ? 8'h0f : 8'hff;
      bus.s_tuser[h*8 +: 8]    = beat[h] == 0 ? (len[h] == 1 ? 8'h03 : 8'h01) :
                                 (beat[h] == len[h] - 2 ? 8'h02 : 8'h00);
      bus.s_tid[h]             = 1'(h);
    end
  end

  // reference model: job owner, round-robin pointer, per-host job counts
  bit m_busy = 1'b0, chk_en = 1'b0, m_found;
  int m_g = 0, m_ptr = 0;
  int m_cnt[N];
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_ptr = 0; m_g = 0;
      for (int h = 0; h < N; h++) m_cnt[h] = 0;
    end else if (!m_busy) begin
      m_found = 1'b0;
      for (int k = 0; k < N; k++)
        if (!m_found && bus.s_tvalid[(m_ptr + k) % N]) begin
          m_found = 1'b1; m_busy = 1'b1; m_g = (m_ptr + k) % N;
        end
    end else if (bus.s_tvalid[m_g] && bus.ib_tready && bus.s_tlast[m_g]) begin
      m_busy = 1'b0;
      m_ptr  = (m_g + 1) % N;
      if (m_cnt[m_g] < 65535) m_cnt[m_g]++;
    end
    chk_en = 1'b1;
  end
  logic [127:0] ev, av;
  bit act;
  always @(negedge clk) if (chk_en) begin
    act = m_busy && !rst;
    ev = {38'd0, act ? 4'(bus.ib_tready) << m_g : 4'd0,
          act & bus.s_tvalid[m_g], act & bus.s_tlast[m_g],
          act ? bus.s_tdata[m_g*64 +: 64] : 64'd0, act ? bus.s_tstrb[m_g*8 +: 8] : 8'd0,
          act ? bus.s_tuser[m_g*8 +: 8] : 8'd0, act & bus.s_tid[m_g], m_busy, 2'(m_g)};
    av = {38'd0, bus.s_tready, bus.ib_tvalid, bus.ib_tlast, bus.ib_tdata, bus.ib_tstrb,
          bus.ib_tuser, bus.ib_tid, grant_vld, grant_idx};
    chk("cycle", av, ev);
`ifdef CR_CCEIP_IB_ARB_STATS_EN
    chk("job_cnt", 128'(job_cnt), 128'({16'(m_cnt[3]), 16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])}));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_quiet(input int budget, input string n);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!grant_vld && jobs[0] == 0 && jobs[1] == 0 && jobs[2] == 0 && jobs[3] == 0) return;
    end
    chk({n, "_timeout"}, 128'(0), 128'(1));
  endtask
  task automatic wait_gvld(input int budget, input string n);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (grant_vld) return;
    end
    chk({n, "_timeout"}, 128'(0), 128'(1));
  endtask

  logic [63:0] d0;
  int j0;
  initial begin
    bus.ib_tready = 1'b1;
    for (int h = 0; h < N; h++) begin
      len[h] = 1; jobs[h] = 1; beat[h] = 0; jid[h] = 0; hold[h] = 1'b0;
    end
    // T1: reset with every host requesting
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t1_idle_gvld", 128'(grant_vld), 128'(0));
    chk("t1_idle_rdy", 128'(bus.s_tready), 128'(0));
    @(negedge clk);
    chk("t1_gvld", 128'(grant_vld), 128'(1));
    chk("t1_gidx", 128'(grant_idx), 128'(0));
    chk("t1_rdy", 128'(bus.s_tready), 128'(4'b0001));
    wait_quiet(100, "t1");
    chk("t1_njobs", 128'(grant_log.size()), 128'(4));
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("t1_order", 128'(grant_log[i]), 128'(i));
    // T2: single 9-beat job from host 2
    tick();
    log_q.delete();
    j0 = jid[2];
    len[2] = 9; jobs[2] = 1;
    wait_quiet(100, "t2");
    chk("t2_beats", 128'(log_q.size()), 128'(9));
    for (int b = 0; b < 9 && b < log_q.size(); b++) begin
      chk("t2_idx", 128'(log_q[b].idx), 128'(2));
      chk("t2_data", 128'(log_q[b].d), 128'(beat_data(2, j0, b)));
      chk("t2_last", 128'(log_q[b].l), 128'(b == 8));
    end
    if (log_q.size() == 9) begin
      chk("t2_strb7", 128'(log_q[7].s), 128'(8'h0f));
      chk("t2_user7", 128'(log_q[7].u), 128'(8'h02));
    end
    tick();
    grant_log.delete();
    len[2] = 1; jobs[0] = 1; jobs[3] = 1;
    wait_quiet(100, "t2_ptr");
    chk("t2_ptr_n", 128'(grant_log.size()), 128'(2));
    if (grant_log.size() == 2) begin
      chk("t2_ptr_first", 128'(grant_log[0]), 128'(3));
      chk("t2_ptr_second", 128'(grant_log[1]), 128'(0));
    end
    // T3: fairness with all hosts streaming 3-beat jobs
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    grant_log.delete(); grant_cyc.delete(); log_q.delete();
    for (int h = 0; h < N; h++) begin len[h] = 3; jobs[h] = 2; end
    wait_quiet(200, "t3");
    chk("t3_njobs", 128'(grant_log.size()), 128'(8));
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("t3_order", 128'(grant_log[i]), 128'(i % 4));
    if (grant_cyc.size() >= 5) chk("t3_round", 128'(grant_cyc[4] - grant_cyc[0]), 128'(16));
    chk("t3_beats", 128'(log_q.size()), 128'(24));
    for (int k = 0; k < log_q.size(); k++) begin
      chk("t3_noint", 128'(log_q[k].idx), 128'(log_q[k - k % 3].idx));
      chk("t3_host", 128'(log_q[k].d[63:56]), 128'(log_q[k].idx));
    end
    // T4: backpressure on the tlast beat
    tick();
    bus.ib_tready = 1'b0;
    len[0] = 1; jobs[0] = 1;
    wait_gvld(20, "t4");
    d0 = bus.ib_tdata;
    chk("t4_data", 128'(d0), 128'(beat_data(0, jid[0], 0)));
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_gvld", 128'(grant_vld), 128'(1));
      chk("t4_hold_last", 128'(bus.ib_tlast), 128'(1));
      chk("t4_hold_data", 128'(bus.ib_tdata), 128'(d0));
      @(negedge clk);
    end
    tick();
    bus.ib_tready = 1'b1;
    @(negedge clk);
    chk("t4_accept_cycle", 128'(grant_vld), 128'(1));
    @(negedge clk);
    chk("t4_end", 128'(grant_vld), 128'(0));
    // T5: host 1 pauses mid-job while host 0 waits
    tick();
    grant_log.delete();
    len[1] = 4; jobs[1] = 1;
    wait_gvld(20, "t5");
    chk("t5_gidx", 128'(grant_idx), 128'(1));
    tick();
    hold[1] = 1'b1; len[0] = 1; jobs[0] = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_gidx_held", 128'(grant_idx), 128'(1));
      chk("t5_gvld_held", 128'(grant_vld), 128'(1));
      chk("t5_rdy0", 128'(bus.s_tready[0]), 128'(0));
    end
    tick();
    hold[1] = 1'b0;
    wait_quiet(100, "t5");
    chk("t5_njobs", 128'(grant_log.size()), 128'(2));
    if (grant_log.size() == 2) chk("t5_next", 128'(grant_log[1]), 128'(0));
`ifdef CR_CCEIP_IB_ARB_STATS_EN
    // T6: counter saturation and clear
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_clear", 128'(job_cnt), 128'(0));
    tick();
    len[3] = 1; jobs[3] = 70000;
    wait_quiet(150000, "t6");
    chk("t6_sat", 128'(job_cnt), 128'({16'hffff, 48'd0}));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_reclear", 128'(job_cnt), 128'(0));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
